// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers.
// Ports: clk, rst; start/op/rs_data/rt_data launch an op; cancel aborts it;
// hi_we/lo_we/wdata implement mthi/mtlo; busy, done, hi, lo are outputs.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] rs_raw_q, rs_raw_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Operand magnitudes; op[0]=0 selects the signed flavour.
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;

    assign rs_neg = ~op[0] & rs_data[31];
    assign rt_neg = ~op[0] & rt_data[31];
    assign rs_mag = rs_neg ? (32'd0 - rs_data) : rs_data;
    assign rt_mag = rt_neg ? (32'd0 - rt_data) : rt_data;

    // Multiply step: acc = {partial, multiplier}; add on the
    // low multiplier bit, then shift the whole pair right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[63:32]}
                    + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide step: acc = {remainder, dividend/quotient}. The
    // remainder stays below 2^31 until the final step, so a
    // 33-bit trial subtract is wide enough.
    logic [32:0] div_trial;
    logic        div_ok;
    logic [63:0] div_next;

    assign div_trial = acc_q[63:31] - {1'b0, opnd_q};
    assign div_ok    = ~div_trial[32];
    assign div_next  = {div_ok ? div_trial[31:0] : acc_q[62:31],
                        acc_q[30:0], div_ok};

    // Final sign correction.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] fix_hi, fix_lo;

    assign prod_fix = neg_quo_q ? (64'd0 - acc_q) : acc_q;
    assign quo_fix  = neg_quo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_comb begin
        fix_hi = prod_fix[63:32];
        fix_lo = prod_fix[31:0];
        if (is_div_q) begin
            if (opnd_q == 32'd0) begin
                // Divide by zero reports the untouched dividend.
                fix_hi = rs_raw_q;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quo_fix;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        rs_raw_d  = rs_raw_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (hi_we) begin
                    hi_d = wdata;
                end
                if (lo_we) begin
                    lo_d = wdata;
                end
                if (start && !cancel) begin
                    state_d   = S_RUN;
                    cnt_d     = 5'd0;
                    is_div_d  = op[1];
                    neg_quo_d = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    rs_raw_d  = rs_data;
                    opnd_d    = op[1] ? rt_mag : rs_mag;
                    acc_d     = {32'd0, op[1] ? rs_mag : rt_mag};
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    hi_d   = fix_hi;
                    lo_d   = fix_lo;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= 32'd0;
            rs_raw_q  <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            rs_raw_q  <= rs_raw_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors with
// hand-computed HI/LO, checked by a monitor on every done pulse.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    mult_div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .cancel  (cancel),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected {HI,LO}.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: hi=%h lo=%h", hi, lo);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hi", hi, mon_e[63:32]);
                check("result_lo", lo, mon_e[31:0]);
            end
        end
    end

    // Issue one op, push its expectation, then verify busy/latency.
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh,
                         input logic [31:0] el, input logic wr_lo);
        int n;
        int busy_err;
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        lo_we   = wr_lo;
        wdata   = 32'hAAAA_5555;
        exp_q.push_back({eh, el});
        @(posedge clk);
        #1;
        start   = 1'b0;
        lo_we   = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        if (wr_lo) begin
            check("mtlo_with_start", lo, 32'hAAAA_5555);
        end
        n = 0;
        busy_err = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) begin
                busy_err++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 33);
        check("busy_during_op", busy_err, 0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic mt(input logic is_hi, input logic [31:0] v);
        @(negedge clk);
        hi_we = is_hi;
        lo_we = ~is_hi;
        wdata = v;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = 32'd0;
        rt_data = 32'd0;
        cancel  = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = 32'd0;
        #12;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue(2'b00, 32'hFFFF_FFFD, 32'd5,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0000_0000, 1'b0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b1);
        issue(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0);
        issue(2'b10, 32'hFFFF_FFFB, 32'd0,
              32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h8000_0000, 1'b0);

        // mthi in IDLE, then a cancelled mult with a stray start.
        mt(1'b1, 32'h0000_1234);
        check("mthi_idle", hi, 32'h0000_1234);
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b00;
        rs_data = 32'd2;
        rt_data = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cancel = 1'b1;
        check("busy_before_cancel", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("busy_after_cancel", {31'd0, busy}, 32'd0);
        check("cancel_hi", hi, 32'h0000_1234);
        check("cancel_lo", lo, 32'h8000_0000);
        repeat (40) @(posedge clk);
        #1;
        check("idle_after_cancel", {31'd0, busy}, 32'd0);
        check("cancel_hi_later", hi, 32'h0000_1234);

        // Async reset in the middle of a divide.
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b11;
        rs_data = 32'd100;
        rt_data = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(2'b01, 32'd4, 32'd4, 32'd0, 32'd16, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
